// File: rtl/sr_drv_pkg.sv
// Shared types and constants for the SR latch command sequencer.
package sr_drv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_PULSE   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_SETTLE  = 3'd4,
        ST_CHECK   = 3'd5
    } state_t;

    localparam logic [1:0] CMD_NOP = 2'b00;
    localparam logic [1:0] CMD_SET = 2'b01;
    localparam logic [1:0] CMD_RST = 2'b10;
    localparam logic [1:0] CMD_ILL = 2'b11;

    localparam int ERR_CNT_W = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sr_drv_timer.sv
// Loadable down-counter used to time the PULSE and SETTLE phases.
module sr_drv_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             expire
);

    logic [WIDTH-1:0] count;

    // Load on phase entry, then count down while the phase is active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == WIDTH'(1));

endmodule

// File: rtl/sr_latch_driver.sv
// Sequencer turning one-cycle set/reset/nop commands into a safe S/R/EN
// waveform for a gated SR latch, with readback checking of Q/Qbar.
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int PULSE_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    input  logic [1:0]           cmd,
    output logic                 cmd_ready,
    output logic                 S,
    output logic                 R,
    output logic                 EN,
    input  logic                 Q,
    input  logic                 Qbar,
    output logic                 done,
    output logic                 rejected,
    output logic                 mismatch,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 exp_q
);

    localparam int MAX_CYC = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);

    state_t        state;
    state_t        next_state;
    logic          op_set;
    logic          next_op_set;
    logic          accept;
    logic          accept_op;
    logic          drive_next;
    logic          readback_fail;
    logic          timer_load;
    logic          timer_en;
    logic [TW-1:0] timer_val;
    logic          timer_expire;

    assign cmd_ready = (state == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign accept_op = accept && ((cmd == CMD_SET) || (cmd == CMD_RST));
    assign timer_en  = (state == ST_PULSE) || (state == ST_SETTLE);

    sr_drv_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (timer_load),
        .en      (timer_en),
        .load_val(timer_val),
        .expire  (timer_expire)
    );

    // Next-state logic; the timer is loaded on the edge entering PULSE or SETTLE.
    always_comb begin
        next_state = state;
        timer_load = 1'b0;
        timer_val  = '0;
        case (state)
            ST_IDLE: begin
                if (accept_op) begin
                    next_state = ST_SETUP;
                end
            end
            ST_SETUP: begin
                next_state = ST_PULSE;
                timer_load = 1'b1;
                timer_val  = TW'(PULSE_CYCLES);
            end
            ST_PULSE: begin
                if (timer_expire) begin
                    next_state = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (SETTLE_CYCLES == 0) begin
                    next_state = ST_CHECK;
                end else begin
                    next_state = ST_SETTLE;
                    timer_load = 1'b1;
                    timer_val  = TW'(SETTLE_CYCLES);
                end
            end
            ST_SETTLE: begin
                if (timer_expire) begin
                    next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Operation polarity for the coming cycle and the readback verdict.
    // Q/Qbar are judged on the edge entering CHECK so that mismatch can be
    // registered and still line up with done; the latch has been closed since
    // RELEASE, so its outputs are stable by then.
    always_comb begin
        next_op_set = op_set;
        if (accept_op) begin
            next_op_set = (cmd == CMD_SET);
        end
        drive_next    = (next_state == ST_SETUP) || (next_state == ST_PULSE) ||
                        (next_state == ST_RELEASE);
        readback_fail = (Q != exp_q) || (Q == Qbar);
    end

    // State register plus the captured operation and expected latch value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            op_set <= 1'b0;
            exp_q  <= 1'b0;
        end else begin
            state  <= next_state;
            op_set <= next_op_set;
            if (accept_op) begin
                exp_q <= (cmd == CMD_SET);
            end
        end
    end

    // Registered latch drive and status pulses decoded from the next state;
    // S and R are mutually exclusive because both derive from one polarity bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            S        <= 1'b0;
            R        <= 1'b0;
            EN       <= 1'b0;
            done     <= 1'b0;
            rejected <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            S        <= drive_next && next_op_set;
            R        <= drive_next && !next_op_set;
            EN       <= (next_state == ST_PULSE);
            done     <= (next_state == ST_CHECK) || (accept && (cmd == CMD_NOP));
            rejected <= accept && (cmd == CMD_ILL);
            mismatch <= (next_state == ST_CHECK) && readback_fail;
        end
    end

    // Saturating error counter, bumped as the failing CHECK cycle ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if ((state == ST_CHECK) && mismatch) begin
            err_cnt <= sat_inc(err_cnt);
        end
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver driving a behavioural gated SR latch.
module SR_Latch_dataflow (
    input  logic S,
    input  logic R,
    input  logic EN,
    output logic Q,
    output logic Qbar
);
    logic q_state = 1'b0;

    always @(S or R or EN) begin
        if (EN && S && !R) q_state = 1'b1;
        else if (EN && R && !S) q_state = 1'b0;
    end

    assign Q    = q_state;
    assign Qbar = ~q_state;
endmodule

module tb_sr_latch_driver;
    import sr_drv_pkg::*;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd       = 2'b00;
    logic       cmd_ready, s_out, r_out, en_out, done, rejected, mismatch, exp_q;
    logic [7:0] err_cnt;
    logic       latch_q, latch_qbar, q_in, qbar_in;
    logic       force_en = 1'b0, force_q = 1'b0, force_qbar = 1'b1;

    logic       cmd_valid2 = 1'b0;
    logic [1:0] cmd2       = 2'b00;
    logic       cmd_ready2, s2, r2, en2, done2, rejected2, mismatch2, exp_q2;
    logic [7:0] err_cnt2;
    logic       latch2_q, latch2_qbar;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign q_in    = force_en ? force_q : latch_q;
    assign qbar_in = force_en ? force_qbar : latch_qbar;

    sr_latch_driver #(.PULSE_CYCLES(2), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
        .S(s_out), .R(r_out), .EN(en_out), .Q(q_in), .Qbar(qbar_in),
        .done(done), .rejected(rejected), .mismatch(mismatch), .err_cnt(err_cnt), .exp_q(exp_q)
    );

    SR_Latch_dataflow latch (.S(s_out), .R(r_out), .EN(en_out), .Q(latch_q), .Qbar(latch_qbar));

    sr_latch_driver #(.PULSE_CYCLES(1), .SETTLE_CYCLES(0)) dut2 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid2), .cmd(cmd2), .cmd_ready(cmd_ready2),
        .S(s2), .R(r2), .EN(en2), .Q(latch2_q), .Qbar(latch2_qbar),
        .done(done2), .rejected(rejected2), .mismatch(mismatch2), .err_cnt(err_cnt2), .exp_q(exp_q2)
    );

    SR_Latch_dataflow latch2 (.S(s2), .R(r2), .EN(en2), .Q(latch2_q), .Qbar(latch2_qbar));

    // S and R must never be high together on either instance.
    always @(negedge clk) begin
        checks++;
        if (((s_out & r_out) | (s2 & r2)) !== 1'b0) begin
            errors++;
            $display("[TB] FAIL s_and_r at %0t: got S1R1=%b%b S2R2=%b%b expected no S=R=1", $time, s_out, r_out, s2, r2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] c);
        cmd_valid = 1'b1;
        cmd       = c;
        tick();
        cmd_valid = 1'b0;
        cmd       = CMD_NOP;
    endtask

    task automatic run_op(input logic [1:0] c, output int done_at, output logic mm_at);
        done_at = -1;
        mm_at   = 1'b0;
        issue(c);
        for (int k = 1; k <= 20; k++) begin
            if (done && done_at < 0) begin
                done_at = k;
                mm_at   = mismatch;
            end
            if (cmd_ready && k > 1 && done_at >= 0) break;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({cmd_ready, s_out, r_out, en_out, done, rejected, mismatch, exp_q} !== 8'b1000_0000) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected 10000000", {cmd_ready, s_out, r_out, en_out, done, rejected, mismatch, exp_q});
        end
        checks++;
        if (err_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_err_cnt: got %0d expected 0", err_cnt);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_set_hold();
        logic exp_s, exp_en, exp_done, exp_rdy;
        issue(CMD_SET);
        for (int c = 1; c <= 7; c++) begin
            exp_s    = (c >= 1 && c <= 4);
            exp_en   = (c == 2 || c == 3);
            exp_done = (c == 6);
            exp_rdy  = (c == 7);
            checks++;
            if ({s_out, r_out, en_out, done, mismatch, cmd_ready, exp_q} !== {exp_s, 1'b0, exp_en, exp_done, 1'b0, exp_rdy, 1'b1}) begin
                errors++;
                $display("[TB] FAIL set_cycle%0d: got S,R,EN,done,mm,rdy,expq=%b expected %b", c,
                         {s_out, r_out, en_out, done, mismatch, cmd_ready, exp_q}, {exp_s, 1'b0, exp_en, exp_done, 1'b0, exp_rdy, 1'b1});
            end
            tick();
        end
        checks++;
        if (latch_q !== 1'b1) begin
            errors++;
            $display("[TB] FAIL set_latch_q: got %b expected 1", latch_q);
        end
        issue(CMD_NOP);
        checks++;
        if ({done, cmd_ready, en_out, s_out, r_out, latch_q} !== 6'b110001) begin
            errors++;
            $display("[TB] FAIL nop_cycle1: got done,rdy,EN,S,R,Q=%b expected 110001", {done, cmd_ready, en_out, s_out, r_out, latch_q});
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL nop_done_pulse: got %b expected 0", done);
        end
    endtask

    task automatic test_reset_after_set();
        logic exp_r, exp_en, exp_done;
        issue(CMD_RST);
        for (int c = 1; c <= 7; c++) begin
            exp_r    = (c >= 1 && c <= 4);
            exp_en   = (c == 2 || c == 3);
            exp_done = (c == 6);
            checks++;
            if ({s_out, r_out, en_out, done, mismatch} !== {1'b0, exp_r, exp_en, exp_done, 1'b0}) begin
                errors++;
                $display("[TB] FAIL rst_cycle%0d: got S,R,EN,done,mm=%b expected %b", c,
                         {s_out, r_out, en_out, done, mismatch}, {1'b0, exp_r, exp_en, exp_done, 1'b0});
            end
            tick();
        end
        checks++;
        if ({latch_q, exp_q, err_cnt} !== {1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("[TB] FAIL rst_result: got Q=%b exp_q=%b err_cnt=%0d expected Q=0 exp_q=0 err_cnt=0", latch_q, exp_q, err_cnt);
        end
    endtask

    task automatic test_illegal_busy();
        int done_cnt = 0;
        int done_cyc = -1;
        issue(CMD_ILL);
        checks++;
        if ({rejected, done, cmd_ready, s_out, r_out, en_out} !== 6'b101000) begin
            errors++;
            $display("[TB] FAIL illegal_cycle1: got rej,done,rdy,S,R,EN=%b expected 101000", {rejected, done, cmd_ready, s_out, r_out, en_out});
        end
        tick();
        checks++;
        if ({rejected, err_cnt} !== {1'b0, 8'd0}) begin
            errors++;
            $display("[TB] FAIL illegal_after: got rej=%b err_cnt=%0d expected rej=0 err_cnt=0", rejected, err_cnt);
        end
        issue(CMD_SET);
        if (done) done_cnt++;
        tick();
        cmd_valid = 1'b1;
        cmd       = CMD_SET;
        checks++;
        if ({cmd_ready, en_out} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL busy_ready: got rdy,EN=%b expected 01", {cmd_ready, en_out});
        end
        for (int c = 2; c <= 14; c++) begin
            if (c == 3) cmd_valid = 1'b0;
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            tick();
        end
        cmd = CMD_NOP;
        checks++;
        if (done_cnt !== 1 || done_cyc !== 6) begin
            errors++;
            $display("[TB] FAIL busy_done_count: got count=%0d last_cycle=%0d expected count=1 cycle=6", done_cnt, done_cyc);
        end
        checks++;
        if (latch_q !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_latch_q: got %b expected 1", latch_q);
        end
    endtask

    task automatic test_fault();
        int   d;
        logic m;
        int   bad = 0;
        force_en = 1'b1; force_q = 1'b0; force_qbar = 1'b1;
        run_op(CMD_SET, d, m);
        checks++;
        if (d !== 6 || m !== 1'b1 || err_cnt !== 8'd1) begin
            errors++;
            $display("[TB] FAIL fault_q0: got done_at=%0d mm=%b err_cnt=%0d expected 6 1 1", d, m, err_cnt);
        end
        force_q = 1'b1; force_qbar = 1'b1;
        run_op(CMD_SET, d, m);
        checks++;
        if (d !== 6 || m !== 1'b1 || err_cnt !== 8'd2) begin
            errors++;
            $display("[TB] FAIL fault_q_eq_qbar: got done_at=%0d mm=%b err_cnt=%0d expected 6 1 2", d, m, err_cnt);
        end
        force_q = 1'b0; force_qbar = 1'b1;
        for (int i = 0; i < 298; i++) begin
            run_op(CMD_SET, d, m);
            if (d != 6 || m != 1'b1) bad++;
        end
        force_en = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL fault_loop: got %0d bad ops expected 0", bad);
        end
        checks++;
        if (err_cnt !== 8'd255) begin
            errors++;
            $display("[TB] FAIL err_cnt_saturate: got %0d expected 255", err_cnt);
        end
    endtask

    task automatic test_reset_mid_pulse();
        int   d;
        logic m;
        issue(CMD_RST);
        tick();
        checks++;
        if ({en_out, r_out} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL midpulse_pre: got EN,R=%b expected 11", {en_out, r_out});
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({en_out, s_out, r_out, cmd_ready, exp_q, err_cnt} !== {5'b00010, 8'd0}) begin
            errors++;
            $display("[TB] FAIL midpulse_async: got EN,S,R,rdy,expq=%b err_cnt=%0d expected 00010 err_cnt=0",
                     {en_out, s_out, r_out, cmd_ready, exp_q}, err_cnt);
        end
        tick();
        rst = 1'b0;
        tick();
        run_op(CMD_SET, d, m);
        checks++;
        if (d !== 6 || m !== 1'b0 || latch_q !== 1'b1 || exp_q !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midpulse_recover: got done_at=%0d mm=%b Q=%b exp_q=%b expected 6 0 1 1", d, m, latch_q, exp_q);
        end
    endtask

    task automatic test_params();
        logic exp_s, exp_en, exp_done, exp_rdy;
        for (int op = 0; op < 2; op++) begin
            cmd_valid2 = 1'b1;
            cmd2       = (op == 0) ? CMD_SET : CMD_RST;
            tick();
            cmd_valid2 = 1'b0;
            cmd2       = CMD_NOP;
            for (int c = 1; c <= 5; c++) begin
                exp_s    = (c <= 3);
                exp_en   = (c == 2);
                exp_done = (c == 4);
                exp_rdy  = (c == 5);
                checks++;
                if ({s2 | r2, (op == 0) ? s2 : r2, en2, done2, mismatch2, cmd_ready2} !== {exp_s, exp_s, exp_en, exp_done, 1'b0, exp_rdy}) begin
                    errors++;
                    $display("[TB] FAIL short_op%0d_cycle%0d: got drv,drv_ok,EN,done,mm,rdy=%b expected %b", op, c,
                             {s2 | r2, (op == 0) ? s2 : r2, en2, done2, mismatch2, cmd_ready2}, {exp_s, exp_s, exp_en, exp_done, 1'b0, exp_rdy});
                end
                tick();
            end
            checks++;
            if (latch2_q !== ((op == 0) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("[TB] FAIL short_op%0d_q: got %b expected %b", op, latch2_q, (op == 0) ? 1'b1 : 1'b0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_set_hold();
        test_reset_after_set();
        test_illegal_busy();
        test_fault();
        test_reset_mid_pulse();
        test_params();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
